// File: rtl/dff_shift_register_if.sv
// -----------------------------------------------------------------------------
// dff_shift_register_if
//   Bundles the command, data and status signals of dff_shift_register.
//   Clock and asynchronous clear stay as plain ports on the register itself.
//
//   Signals (driven by the master, seen by the slave):
//     en      clock enable for mode operations (does not gate sclr/spre)
//     sclr    synchronous clear to RESET_VALUE
//     spre    synchronous preset to PRESET_VALUE
//     mode    operation select (hold/shr/shl/load/ror/rol, 11x = hold)
//     d       parallel load data
//     sin_r   serial input entering at bit WIDTH-1 on shift right
//     sin_l   serial input entering at bit 0 on shift left
//   Signals (driven by the slave, seen by the master):
//     q       register contents
//     q_n     bitwise complement of q
//     sout_r  q[0], the bit leaving on shift right
//     sout_l  q[WIDTH-1], the bit leaving on shift left
//     changed high for one cycle after an edge that altered q
// -----------------------------------------------------------------------------
interface dff_shift_register_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sclr;
  logic             spre;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             sout_r;
  logic             sout_l;
  logic             changed;

  modport master (
    output en, sclr, spre, mode, d, sin_r, sin_l,
    input  q, q_n, sout_r, sout_l, changed
  );

  modport slave (
    input  en, sclr, spre, mode, d, sin_r, sin_l,
    output q, q_n, sout_r, sout_l, changed
  );
endinterface

// File: rtl/dff_shift_register.sv
// -----------------------------------------------------------------------------
// dff_shift_register
//   WIDTH-bit bank of D flip-flops with asynchronous clear, synchronous
//   clear/preset and a mode select for hold, shift, rotate and parallel load.
//   WIDTH must be at least 2 and must match the WIDTH of the bound interface.
//
//   Ports:
//     clk      rising-edge clock
//     clear_n  asynchronous active-low clear, forces q to RESET_VALUE
//     bus      dff_shift_register_if.slave (commands in, q/q_n/sout/changed out)
//
//   Edge priority, highest first: sclr, spre, en & mode.
// -----------------------------------------------------------------------------
module dff_shift_register #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  clear_n,
  dff_shift_register_if.slave   bus
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic [WIDTH-1:0] w_q_next;

  // NOTE: w_q_next is assigned r_q before any branch, so every path through
  // the block drives it and no latch is inferred.
  always_comb begin
    w_q_next = r_q;
    if (bus.sclr) begin
      w_q_next = RESET_VALUE;
    end else if (bus.spre) begin
      w_q_next = PRESET_VALUE;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_SHR:  w_q_next = {bus.sin_r, r_q[WIDTH-1:1]};
        MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], bus.sin_l};
        MODE_LOAD: w_q_next = bus.d;
        MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
        MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        default:   w_q_next = r_q;  // MODE_HOLD and reserved 11x codes
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so r_changed compares
  // w_q_next against the value r_q held before this edge.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_q       <= RESET_VALUE;
      r_changed <= 1'b0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= (w_q_next != r_q);
    end
  end

  // Derived outputs come straight from r_q so they track it during clear too.
  assign bus.q       = r_q;
  assign bus.q_n     = ~r_q;
  assign bus.sout_r  = r_q[0];
  assign bus.sout_l  = r_q[WIDTH-1];
  assign bus.changed = r_changed;

endmodule

// File: tb/tb_dff_shift_register.sv
module tb_dff_shift_register;

  logic clk = 1'b0;
  logic clear_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dff_shift_register_if #(.WIDTH(8))  u_if8 ();
  dff_shift_register_if #(.WIDTH(2))  u_if2 ();
  dff_shift_register_if #(.WIDTH(32)) u_if32 ();

  dff_shift_register #(.WIDTH(8)) u_dut8 (
    .clk(clk), .clear_n(clear_n), .bus(u_if8)
  );
  dff_shift_register #(.WIDTH(2), .RESET_VALUE(2'b01)) u_dut2 (
    .clk(clk), .clear_n(clear_n), .bus(u_if2)
  );
  dff_shift_register #(.WIDTH(32), .RESET_VALUE(32'h5555_5555)) u_dut32 (
    .clk(clk), .clear_n(clear_n), .bus(u_if32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one mode command to the 8-bit register and clock it.
  task automatic cmd8(input logic en, input logic [2:0] mode,
                      input logic [7:0] d, input logic sr, input logic sl);
    u_if8.en = en; u_if8.mode = mode; u_if8.d = d;
    u_if8.sin_r = sr; u_if8.sin_l = sl;
    tick();
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    #2;
    n_cmp++; if (u_if8.q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", u_if8.q); end
    n_cmp++; if (u_if8.q_n !== 8'hFF) begin n_err++; $display("FAIL reset_q_n: got %h want ff", u_if8.q_n); end
    n_cmp++; if (u_if8.changed !== 1'b0) begin n_err++; $display("FAIL reset_changed: got %b want 0", u_if8.changed); end
    n_cmp++; if ({u_if8.sout_l, u_if8.sout_r} !== 2'b00) begin n_err++; $display("FAIL reset_sout: got %b want 00", {u_if8.sout_l, u_if8.sout_r}); end
    @(negedge clk);
    clear_n = 1'b1;
    cmd8(1'b1, 3'b011, 8'hA5, 1'b0, 1'b0);
    n_cmp++; if (u_if8.q !== 8'hA5) begin n_err++; $display("FAIL load_a5: got %h want a5", u_if8.q); end
    cmd8(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (u_if8.q !== 8'h52) begin n_err++; $display("FAIL shr_a5: got %h want 52", u_if8.q); end
    // Clear mid-stream, between edges, with the shift command still applied.
    #2;
    clear_n = 1'b0;
    #1;
    n_cmp++; if (u_if8.q !== 8'h00) begin n_err++; $display("FAIL async_clr_q: got %h want 00", u_if8.q); end
    n_cmp++; if (u_if8.q_n !== 8'hFF) begin n_err++; $display("FAIL async_clr_q_n: got %h want ff", u_if8.q_n); end
    n_cmp++; if (u_if8.changed !== 1'b0) begin n_err++; $display("FAIL async_clr_changed: got %b want 0", u_if8.changed); end
    @(negedge clk);
    u_if8.mode = 3'b011; u_if8.d = 8'h3C;
    clear_n = 1'b1;
    tick();
    n_cmp++; if (u_if8.q !== 8'h3C) begin n_err++; $display("FAIL release_load: got %h want 3c", u_if8.q); end
    n_cmp++; if (u_if8.changed !== 1'b1) begin n_err++; $display("FAIL release_changed: got %b want 1", u_if8.changed); end
  endtask

  task automatic test_shift_right();
    logic [7:0] seq = 8'b0100_1101;  // seq[0] is applied first: 1,0,1,1,0,0,1,0
    logic [7:0] exp = 8'h00;
    u_if8.sclr = 1'b1;
    tick();
    u_if8.sclr = 1'b0;
    n_cmp++; if (u_if8.q !== 8'h00) begin n_err++; $display("FAIL sclr_to_zero: got %h want 00", u_if8.q); end
    for (int i = 0; i < 8; i++) begin
      cmd8(1'b1, 3'b001, 8'h00, seq[i], 1'b0);
      exp = {seq[i], exp[7:1]};
      n_cmp++; if (u_if8.sout_r !== exp[0]) begin n_err++; $display("FAIL shr_sout_r[%0d]: got %b want %b", i, u_if8.sout_r, exp[0]); end
    end
    n_cmp++; if (u_if8.q !== 8'h4D) begin n_err++; $display("FAIL shr_final: got %h want 4d", u_if8.q); end
  endtask

  task automatic test_shift_left_rotate();
    cmd8(1'b1, 3'b011, 8'h81, 1'b0, 1'b0);
    cmd8(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (u_if8.q !== 8'h03) begin n_err++; $display("FAIL rol_81: got %h want 03", u_if8.q); end
    cmd8(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (u_if8.q !== 8'h81) begin n_err++; $display("FAIL ror_1: got %h want 81", u_if8.q); end
    cmd8(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    cmd8(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (u_if8.q !== 8'h60) begin n_err++; $display("FAIL ror_3: got %h want 60", u_if8.q); end
    cmd8(1'b1, 3'b010, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (u_if8.q !== 8'hC1) begin n_err++; $display("FAIL shl_sin1: got %h want c1", u_if8.q); end
    n_cmp++; if ({u_if8.sout_l, u_if8.sout_r} !== 2'b11) begin n_err++; $display("FAIL shl_sout: got %b want 11", {u_if8.sout_l, u_if8.sout_r}); end
  endtask

  task automatic test_priority();
    u_if8.en = 1'b1; u_if8.mode = 3'b011; u_if8.d = 8'h55;
    u_if8.sclr = 1'b1; u_if8.spre = 1'b1;
    tick();
    n_cmp++; if (u_if8.q !== 8'h00) begin n_err++; $display("FAIL sclr_over_spre: got %h want 00", u_if8.q); end
    u_if8.sclr = 1'b0;
    tick();
    n_cmp++; if (u_if8.q !== 8'hFF) begin n_err++; $display("FAIL spre_over_load: got %h want ff", u_if8.q); end
    u_if8.spre = 1'b0; u_if8.sclr = 1'b1; u_if8.en = 1'b0;
    tick();
    n_cmp++; if (u_if8.q !== 8'h00) begin n_err++; $display("FAIL sclr_en0: got %h want 00", u_if8.q); end
    u_if8.sclr = 1'b0; u_if8.spre = 1'b1;
    tick();
    u_if8.spre = 1'b0;
    n_cmp++; if (u_if8.q !== 8'hFF) begin n_err++; $display("FAIL spre_en0: got %h want ff", u_if8.q); end
    n_cmp++; if (u_if8.changed !== 1'b1) begin n_err++; $display("FAIL spre_en0_changed: got %b want 1", u_if8.changed); end
  endtask

  task automatic test_hold_changed();
    cmd8(1'b1, 3'b011, 8'h77, 1'b0, 1'b0);
    n_cmp++; if (u_if8.changed !== 1'b1) begin n_err++; $display("FAIL load77_changed: got %b want 1", u_if8.changed); end
    cmd8(1'b1, 3'b011, 8'h77, 1'b0, 1'b0);
    n_cmp++; if (u_if8.changed !== 1'b0) begin n_err++; $display("FAIL reload77_changed: got %b want 0", u_if8.changed); end
    cmd8(1'b1, 3'b110, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (u_if8.q !== 8'h77) begin n_err++; $display("FAIL mode110_hold: got %h want 77", u_if8.q); end
    cmd8(1'b1, 3'b111, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (u_if8.q !== 8'h77) begin n_err++; $display("FAIL mode111_hold: got %h want 77", u_if8.q); end
    cmd8(1'b1, 3'b000, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (u_if8.q !== 8'h77) begin n_err++; $display("FAIL mode000_hold: got %h want 77", u_if8.q); end
    cmd8(1'b0, 3'b011, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (u_if8.q !== 8'h77) begin n_err++; $display("FAIL en0_hold: got %h want 77", u_if8.q); end
    n_cmp++; if (u_if8.changed !== 1'b0) begin n_err++; $display("FAIL en0_changed: got %b want 0", u_if8.changed); end
    cmd8(1'b1, 3'b011, 8'hFF, 1'b0, 1'b0);
    cmd8(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (u_if8.changed !== 1'b0) begin n_err++; $display("FAIL ror_ff_changed: got %b want 0", u_if8.changed); end
  endtask

  task automatic test_back_to_back();
    cmd8(1'b1, 3'b011, 8'h12, 1'b0, 1'b0);
    cmd8(1'b1, 3'b001, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (u_if8.q !== 8'h89) begin n_err++; $display("FAIL b2b_shr: got %h want 89", u_if8.q); end
    cmd8(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (u_if8.q !== 8'h12) begin n_err++; $display("FAIL b2b_shl: got %h want 12", u_if8.q); end
    n_cmp++; if (u_if8.changed !== 1'b1) begin n_err++; $display("FAIL b2b_shl_changed: got %b want 1", u_if8.changed); end
    cmd8(1'b1, 3'b011, 8'h12, 1'b0, 1'b0);
    n_cmp++; if (u_if8.changed !== 1'b0) begin n_err++; $display("FAIL b2b_same_load: got %b want 0", u_if8.changed); end
    n_cmp++; if (u_if8.q_n !== 8'hED) begin n_err++; $display("FAIL b2b_q_n: got %h want ed", u_if8.q_n); end
  endtask

  task automatic test_width_sweep();
    // Both wide registers have held their clear value since the last clear_n.
    n_cmp++; if (u_if2.q !== 2'b01) begin n_err++; $display("FAIL w2_start: got %b want 01", u_if2.q); end
    n_cmp++; if (u_if32.q !== 32'h5555_5555) begin n_err++; $display("FAIL w32_start: got %h want 55555555", u_if32.q); end
    u_if2.en = 1'b1;  u_if2.mode = 3'b100;
    u_if32.en = 1'b1; u_if32.mode = 3'b100;
    tick();
    n_cmp++; if (u_if2.q !== 2'b10) begin n_err++; $display("FAIL w2_ror1: got %b want 10", u_if2.q); end
    n_cmp++; if (u_if32.q !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL w32_ror1: got %h want aaaaaaaa", u_if32.q); end
    n_cmp++; if (u_if2.q_n !== 2'b01) begin n_err++; $display("FAIL w2_q_n: got %b want 01", u_if2.q_n); end
    tick();
    u_if2.en = 1'b0;
    n_cmp++; if (u_if2.q !== 2'b01) begin n_err++; $display("FAIL w2_full: got %b want 01", u_if2.q); end
    for (int i = 2; i < 32; i++) begin
      tick();
      n_cmp++; if (u_if32.q_n !== ~u_if32.q) begin n_err++; $display("FAIL w32_q_n[%0d]: got %h want %h", i, u_if32.q_n, ~u_if32.q); end
    end
    u_if32.en = 1'b0;
    n_cmp++; if (u_if32.q !== 32'h5555_5555) begin n_err++; $display("FAIL w32_full: got %h want 55555555", u_if32.q); end
    u_if32.en = 1'b1; u_if32.mode = 3'b101;
    tick();
    u_if32.en = 1'b0;
    n_cmp++; if (u_if32.q !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL w32_rol1: got %h want aaaaaaaa", u_if32.q); end
    n_cmp++; if (u_if32.sout_l !== 1'b1) begin n_err++; $display("FAIL w32_sout_l: got %b want 1", u_if32.sout_l); end
  endtask

  initial begin
    u_if8.en = 1'b0;  u_if8.sclr = 1'b0;  u_if8.spre = 1'b0;  u_if8.mode = 3'b000;
    u_if8.d = '0;     u_if8.sin_r = 1'b0; u_if8.sin_l = 1'b0;
    u_if2.en = 1'b0;  u_if2.sclr = 1'b0;  u_if2.spre = 1'b0;  u_if2.mode = 3'b000;
    u_if2.d = '0;     u_if2.sin_r = 1'b0; u_if2.sin_l = 1'b0;
    u_if32.en = 1'b0; u_if32.sclr = 1'b0; u_if32.spre = 1'b0; u_if32.mode = 3'b000;
    u_if32.d = '0;    u_if32.sin_r = 1'b0; u_if32.sin_l = 1'b0;

    test_reset();
    test_shift_right();
    test_shift_left_rotate();
    test_priority();
    test_hold_changed();
    test_back_to_back();
    test_width_sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
